wb_lsu: RTL and testbench
=========================

# wb_lsu

Write-back stage with an integrated load/store unit. It consumes one instruction at a time from the MEM pipeline register and performs the data-bus access for loads and stores: a request/grant phase, then a response phase. It aligns and extends load data, and produces the single register-file write and the exception flags for the retiring instruction. Its ready output is the `WB_ready_i` seen by the MEM stage.

## Interface
- `XLEN`, 32, datapath width
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `flush_i` in 1: kill the instruction held in this stage
- `MEM_valid_i` in 1: MEM holds a valid instruction
- `WB_ready_o` out 1: stage accepts an instruction this cycle
- `MEM_pc_i` in XLEN: instruction PC
- `MEM_ld_st_info_i` in 5: bit0 load, bit1 store, bits3:2 size (0 B, 1 H, 2 W), bit4 unsigned
- `MEM_rd_wen_i` / `MEM_rd_idx_i` in 1 / 5: destination register
- `MEM_fwd_data_i` in XLEN: ALU or CSR result, for non-loads
- `MEM_alu_res_i` in XLEN: effective address for loads and stores
- `MEM_rs2_rdata_i` in XLEN: store data
- `dbus_req_o` out 1, `dbus_we_o` out 1, `dbus_addr_o` out XLEN, `dbus_wdata_o` out XLEN, `dbus_wstrb_o` out 4: request channel
- `dbus_gnt_i` in 1: request accepted
- `dbus_rvalid_i` in 1, `dbus_rdata_i` in XLEN, `dbus_err_i` in 1: response channel; each request gets exactly one response, including stores
- `WB_valid_o` out 1: instruction retires this cycle
- `WB_pc_o` out XLEN, `WB_rd_wen_o` out 1, `WB_rd_idx_o` out 5, `WB_rd_wdata_o` out XLEN: register-file write
- `WB_ld_misalign_o`, `WB_st_misalign_o`, `WB_bus_err_o` out 1 each: exception flags

## Operation
- FSM states:
  - IDLE: empty
  - REQ: `dbus_req_o` high
  - RESP: waiting for `dbus_rvalid_i`
  - DONE: result held
- `WB_ready_o` = state is IDLE or DONE.
- Acceptance: `WB_ready_o && MEM_valid_i && !flush_i` latches all inputs.
- Next state after acceptance:
  - non-memory instruction, or misaligned access → DONE
  - aligned load/store → REQ
- Misalignment:
  - H access with `addr[0]` set, or W access with `addr[1:0]` nonzero
  - raises `ld_misalign` or `st_misalign`
  - no bus access; `rd_wen` is forced to 0.
- REQ:
  - `dbus_addr_o` = `{addr[XLEN-1:2], 2'b00}`
  - `dbus_we_o` = store
  - `dbus_wdata_o` = size-replicated rs2 (B: byte×4, H: half×2, W: word)
  - `dbus_wstrb_o` = B `4'b0001<<addr[1:0]`, H `4'b0011<<addr[1:0]`, W `4'b1111`, loads `4'b0000`
  - request fields stay stable until `dbus_gnt_i` arrives
  - on `dbus_gnt_i` → RESP
- RESP:
  - on `dbus_rvalid_i` → DONE
  - capture data shifted right by `8*addr[1:0]`, then zero-extend (unsigned) or sign-extend to XLEN for size B/H
  - `dbus_err_i` sets `bus_err` and clears `rd_wen`
- DONE:
  - `WB_valid_o` = 1 unless `flush_i`
  - retires unconditionally; next state is DONE (new accept), REQ (new aligned access) or IDLE
- `WB_rd_wdata_o` = aligned load data for loads, else `MEM_fwd_data_i`.
- Writes to x0 are suppressed: `WB_rd_wen_o` = 0 when `rd_idx` = 0.
- All `WB_*` outputs are 0 whenever `WB_valid_o` = 0.
- Flush:
  - in REQ before grant: drop request, → IDLE
  - in REQ on the grant cycle, or in RESP: mark killed, stay until `rvalid`, then → IDLE without retiring
  - in DONE: no retire, and no accept that cycle
- Reset: state IDLE; all outputs 0, including `dbus_req_o`.

## Timing
- Non-memory instruction: accepted at edge N, `WB_valid_o` during cycle N+1. Throughput is 1/cycle (DONE→DONE).
- Load/store with zero-wait bus (gnt during first REQ cycle, rvalid the next cycle): accept edge N, REQ N+1, RESP N+2, `WB_valid_o` in N+3.
- `WB_ready_o` is low during REQ and RESP; MEM stalls.
- `dbus_rvalid_i` outside RESP is ignored. `dbus_gnt_i` while `req` is low is ignored.
- `rst` in any state returns to IDLE next cycle, even mid-transaction.

## Structure
- The `ld_st_info` field positions, the size encodings and `XLEN` go in `defines.v`, shared with the EX and MEM stages.
- One sub-module, `lsu_align`: combinational store-data/strobe generation, load extraction and sign extension, misalignment detection.
- The FSM and the retire register stay in `wb_lsu`.

## Test plan
- ALU ops back-to-back, rd=5, data `0x11`, `0x22` → `WB_valid_o` on consecutive cycles with matching data; `WB_ready_o` stays 1.
- `lb` at `0x1003`, rdata `0x80FF_0000` → `wstrb` 0, addr `0x1000`, `WB_rd_wdata_o` = `0xFFFF_FF80`; `lbu` → `0x0000_0080`.
- `sh` at `0x2002`, rs2 `0x1234` → wdata `0x1234_1234`, wstrb `4'b1100`; gnt delayed 3 cycles → req/addr/wdata stable, retire after rvalid with `rd_wen` 0.
- `lw` at `0x3001` → no `dbus_req_o`, `WB_ld_misalign_o`=1 next cycle, `rd_wen` 0; `sw` at `0x3002` → `WB_st_misalign_o`=1.
- Load answered with `dbus_err_i`=1 → `WB_bus_err_o`=1, `WB_rd_wen_o`=0.
- `flush_i` during RESP → no retire after rvalid; next instruction accepted cleanly. `rst` asserted in REQ → `dbus_req_o`=0 and `WB_ready_o`=1 next cycle.

Source files
------------

// File: rtl/wb_lsu_pkg.sv
// Shared definitions for the write-back / load-store stage: ld_st_info field
// positions, access-size encodings, datapath width and the FSM state type.
package wb_lsu_pkg;

  localparam int XLEN = 32;

  // ld_st_info bit positions, shared with the EX and MEM stages
  localparam int LS_LOAD     = 0;
  localparam int LS_STORE    = 1;
  localparam int LS_SIZE_LSB = 2;
  localparam int LS_UNSIGNED = 4;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } wb_state_e;

  // Unused size encoding 3 is treated like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: store replication and byte strobes, load
// extraction with sign/zero extension, and misalignment detection.
module lsu_align
  import wb_lsu_pkg::*;
(
  input  logic [1:0]      in_size,
  input  logic [1:0]      in_addr_lo,
  output logic            misalign,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [1:0]      addr_lo,
  input  logic            is_store,
  input  logic [XLEN-1:0] st_data,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    misalign = is_misaligned(in_size, in_addr_lo);
    shifted  = rdata >> {addr_lo, 3'b000};
    wdata    = st_data;
    wstrb    = 4'b1111;
    ld_data  = shifted;
    case (size)
      SIZE_B: begin
        wdata   = {4{st_data[7:0]}};
        wstrb   = 4'b0001 << addr_lo;
        ld_data = {{(XLEN-8){~uns & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        wdata   = {2{st_data[15:0]}};
        wstrb   = 4'b0011 << addr_lo;
        ld_data = {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
    if (!is_store) wstrb = 4'b0000;
  end

endmodule

// File: rtl/wb_lsu.sv
// Write-back stage with integrated load/store unit: one instruction at a time,
// request/grant then response on the data bus, single register-file write.
module wb_lsu
  import wb_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            MEM_valid_i,
  output logic            WB_ready_o,
  input  logic [XLEN-1:0] MEM_pc_i,
  input  logic [4:0]      MEM_ld_st_info_i,
  input  logic            MEM_rd_wen_i,
  input  logic [4:0]      MEM_rd_idx_i,
  input  logic [XLEN-1:0] MEM_fwd_data_i,
  input  logic [XLEN-1:0] MEM_alu_res_i,
  input  logic [XLEN-1:0] MEM_rs2_rdata_i,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  output logic [3:0]      dbus_wstrb_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  input  logic            dbus_err_i,
  output logic            WB_valid_o,
  output logic [XLEN-1:0] WB_pc_o,
  output logic            WB_rd_wen_o,
  output logic [4:0]      WB_rd_idx_o,
  output logic [XLEN-1:0] WB_rd_wdata_o,
  output logic            WB_ld_misalign_o,
  output logic            WB_st_misalign_o,
  output logic            WB_bus_err_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: an instruction moves in on a clock edge where WB_ready_o and
  // MEM_valid_i are both high and flush_i is low; a bus request is taken on an
  // edge where dbus_req_o and dbus_gnt_i are both high, and its single
  // response arrives on an edge with dbus_rvalid_i high while in RESP.

  wb_state_e       state;
  logic [XLEN-1:0] pc_q, fwd_q, addr_q, rs2_q, ld_data_q;
  logic [1:0]      size_q;
  logic [4:0]      rd_idx_q;
  logic            uns_q, load_q, store_q, rd_wen_q;
  logic            ld_mis_q, st_mis_q, bus_err_q, killed_q;
  logic            accept, in_mem, in_mis, wb_valid;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [3:0]      st_wstrb;

  lsu_align u_align (
    .in_size    (MEM_ld_st_info_i[LS_SIZE_LSB +: 2]),
    .in_addr_lo (MEM_alu_res_i[1:0]),
    .misalign   (in_mis),
    .size       (size_q),
    .uns        (uns_q),
    .addr_lo    (addr_q[1:0]),
    .is_store   (store_q),
    .st_data    (rs2_q),
    .wdata      (st_wdata),
    .wstrb      (st_wstrb),
    .rdata      (dbus_rdata_i),
    .ld_data    (ld_data)
  );

  assign WB_ready_o = (state == ST_IDLE) || (state == ST_DONE);
  assign accept     = WB_ready_o && MEM_valid_i && !flush_i;
  assign in_mem     = MEM_ld_st_info_i[LS_LOAD] || MEM_ld_st_info_i[LS_STORE];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc_q      <= '0;
      fwd_q     <= '0;
      addr_q    <= '0;
      rs2_q     <= '0;
      ld_data_q <= '0;
      size_q    <= '0;
      rd_idx_q  <= '0;
      uns_q     <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      rd_wen_q  <= 1'b0;
      ld_mis_q  <= 1'b0;
      st_mis_q  <= 1'b0;
      bus_err_q <= 1'b0;
      killed_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // DONE retires unconditionally this cycle; a new accept may overlap it
          if (accept) begin
            pc_q      <= MEM_pc_i;
            load_q    <= MEM_ld_st_info_i[LS_LOAD];
            store_q   <= MEM_ld_st_info_i[LS_STORE];
            size_q    <= MEM_ld_st_info_i[LS_SIZE_LSB +: 2];
            uns_q     <= MEM_ld_st_info_i[LS_UNSIGNED];
            rd_idx_q  <= MEM_rd_idx_i;
            fwd_q     <= MEM_fwd_data_i;
            addr_q    <= MEM_alu_res_i;
            rs2_q     <= MEM_rs2_rdata_i;
            ld_data_q <= '0;
            rd_wen_q  <= MEM_rd_wen_i && !(in_mem && in_mis);
            ld_mis_q  <= MEM_ld_st_info_i[LS_LOAD] && in_mis;
            st_mis_q  <= MEM_ld_st_info_i[LS_STORE] && in_mis;
            bus_err_q <= 1'b0;
            killed_q  <= 1'b0;
            state     <= (in_mem && !in_mis) ? ST_REQ : ST_DONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // once granted, the bus owes a response even if we were flushed
          if (dbus_gnt_i) begin
            killed_q <= flush_i;
            state    <= ST_RESP;
          end else if (flush_i) begin
            state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (flush_i) killed_q <= 1'b1;
          if (dbus_rvalid_i) begin
            if (killed_q || flush_i) begin
              state <= ST_IDLE;
            end else begin
              ld_data_q <= ld_data;
              bus_err_q <= dbus_err_i;
              if (dbus_err_i) rd_wen_q <= 1'b0;
              state <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbus_req_o   = (state == ST_REQ);
  assign dbus_we_o    = dbus_req_o && store_q;
  assign dbus_addr_o  = dbus_req_o ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dbus_wdata_o = dbus_req_o ? st_wdata : '0;
  assign dbus_wstrb_o = dbus_req_o ? st_wstrb : 4'b0000;

  assign wb_valid         = (state == ST_DONE) && !flush_i;
  assign WB_valid_o       = wb_valid;
  assign WB_pc_o          = wb_valid ? pc_q : '0;
  assign WB_rd_wen_o      = wb_valid && rd_wen_q && (rd_idx_q != 5'd0);
  assign WB_rd_idx_o      = wb_valid ? rd_idx_q : 5'd0;
  assign WB_rd_wdata_o    = wb_valid ? (load_q ? ld_data_q : fwd_q) : '0;
  assign WB_ld_misalign_o = wb_valid && ld_mis_q;
  assign WB_st_misalign_o = wb_valid && st_mis_q;
  assign WB_bus_err_o     = wb_valid && bus_err_q;
  assign dbg_state_o      = state;

endmodule

// File: tb/tb_wb_lsu.sv
// Testbench for wb_lsu: directed and randomized ALU/load/store traffic against
// an arithmetic reference model, plus flush and mid-transaction reset cases.
module tb_wb_lsu;

  logic        clk, rst, flush_i;
  logic        MEM_valid_i, WB_ready_o;
  logic [31:0] MEM_pc_i, MEM_fwd_data_i, MEM_alu_res_i, MEM_rs2_rdata_i;
  logic [4:0]  MEM_ld_st_info_i, MEM_rd_idx_i;
  logic        MEM_rd_wen_i;
  logic        dbus_req_o, dbus_we_o, dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
  logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
  logic [3:0]  dbus_wstrb_o;
  logic        WB_valid_o, WB_rd_wen_o, WB_ld_misalign_o, WB_st_misalign_o, WB_bus_err_o;
  logic [31:0] WB_pc_o, WB_rd_wdata_o;
  logic [4:0]  WB_rd_idx_o;
  logic [1:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [69:0] exp_q[$];  // {pc, wen, idx, data}

  wb_lsu dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .MEM_valid_i(MEM_valid_i), .WB_ready_o(WB_ready_o),
    .MEM_pc_i(MEM_pc_i), .MEM_ld_st_info_i(MEM_ld_st_info_i),
    .MEM_rd_wen_i(MEM_rd_wen_i), .MEM_rd_idx_i(MEM_rd_idx_i),
    .MEM_fwd_data_i(MEM_fwd_data_i), .MEM_alu_res_i(MEM_alu_res_i),
    .MEM_rs2_rdata_i(MEM_rs2_rdata_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_wstrb_o(dbus_wstrb_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i),
    .WB_valid_o(WB_valid_o), .WB_pc_o(WB_pc_o), .WB_rd_wen_o(WB_rd_wen_o),
    .WB_rd_idx_o(WB_rd_idx_o), .WB_rd_wdata_o(WB_rd_wdata_o),
    .WB_ld_misalign_o(WB_ld_misalign_o), .WB_st_misalign_o(WB_st_misalign_o),
    .WB_bus_err_o(WB_bus_err_o), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [31:0] addr, input logic [1:0] size);
    return (addr % nbytes_of(size)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input bit uns);
    longint word = longint'(rdata);
    longint m    = longint'(1) << (8 * nbytes_of(size));
    longint v    = (word >> (8 * (addr % 4))) % m;
    if (!uns && nbytes_of(size) < 4 && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input logic [1:0] size);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % nbytes_of(size)) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] s;
    int off = addr % 4;
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + nbytes_of(size));
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush_i = 0; MEM_valid_i = 0; MEM_pc_i = 0; MEM_ld_st_info_i = 0;
    MEM_rd_wen_i = 0; MEM_rd_idx_i = 0; MEM_fwd_data_i = 0; MEM_alu_res_i = 0;
    MEM_rs2_rdata_i = 0; dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0; dbus_err_i = 0;
  endtask

  task automatic drive_op(input logic [31:0] pc, input logic [4:0] info, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] fwd,
                          input logic [4:0] rd, input logic wen);
    MEM_valid_i = 1; MEM_pc_i = pc; MEM_ld_st_info_i = info; MEM_alu_res_i = addr;
    MEM_rs2_rdata_i = rs2; MEM_fwd_data_i = fwd; MEM_rd_idx_i = rd; MEM_rd_wen_i = wen;
  endtask

  // Issues one instruction from a ready stage, plays the bus with the given
  // delays, and reports what the DUT did; called at a negedge, returns at one.
  task automatic run_mem(input logic [4:0] info, input logic [31:0] addr, rs2, fwd, rdata,
                         input logic [4:0] rd, input logic wen, input int gnt_dly, rv_dly,
                         input logic err,
                         output logic req_seen, output logic [31:0] q_addr, q_wdata,
                         output logic [3:0] q_wstrb, output logic q_we, output logic stable,
                         output int lat, output logic r_valid, r_wen, r_ldm, r_stm, r_berr,
                         output logic [31:0] r_wdata);
    drive_op(32'h8000_0000, info, addr, rs2, fwd, rd, wen);
    lat = 0; stable = 1;
    @(negedge clk); lat++; MEM_valid_i = 0;
    req_seen = dbus_req_o; q_addr = dbus_addr_o; q_wdata = dbus_wdata_o;
    q_wstrb = dbus_wstrb_o; q_we = dbus_we_o;
    if (req_seen) begin
      for (int k = 0; k <= gnt_dly; k++) begin
        if (k > 0) begin @(negedge clk); lat++; end
        if (dbus_req_o !== 1'b1 || dbus_addr_o !== q_addr || dbus_wdata_o !== q_wdata ||
            dbus_wstrb_o !== q_wstrb || dbus_we_o !== q_we || WB_ready_o !== 1'b0) stable = 0;
        dbus_gnt_i = (k == gnt_dly);
      end
      @(negedge clk); lat++; dbus_gnt_i = 0;
      for (int k = 0; k <= rv_dly; k++) begin
        if (k > 0) begin @(negedge clk); lat++; end
        if (dbus_req_o !== 1'b0 || WB_ready_o !== 1'b0 || WB_valid_o !== 1'b0) stable = 0;
        dbus_rvalid_i = (k == rv_dly);
        dbus_rdata_i  = (k == rv_dly) ? rdata : $urandom;
        dbus_err_i    = (k == rv_dly) ? err : 1'b0;
      end
      @(negedge clk); lat++; dbus_rvalid_i = 0; dbus_err_i = 0;
    end
    r_valid = WB_valid_o; r_wen = WB_rd_wen_o; r_ldm = WB_ld_misalign_o;
    r_stm = WB_st_misalign_o; r_berr = WB_bus_err_o; r_wdata = WB_rd_wdata_o;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1;
    repeat (3) @(negedge clk);
    tests_run++; if (WB_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b exp 1", WB_ready_o); end
    tests_run++; if (WB_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", WB_valid_o); end
    tests_run++; if (dbus_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b exp 0", dbus_req_o); end
    tests_run++; if (WB_rd_wdata_o !== 32'h0 || dbus_addr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h/%h exp 0/0", WB_rd_wdata_o, dbus_addr_o); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_alu_back_to_back(input int n);
    logic [31:0] pc, fwd;
    logic [4:0]  rd;
    logic        wen;
    logic [69:0] e;
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        tests_run++; if (WB_valid_o !== 1'b1) begin tests_failed++; $display("FAIL alu_valid[%0d]: got %b exp 1", i-1, WB_valid_o); end
        tests_run++; if (WB_ready_o !== 1'b1) begin tests_failed++; $display("FAIL alu_ready[%0d]: got %b exp 1", i-1, WB_ready_o); end
        tests_run++; if ({WB_pc_o, WB_rd_wen_o, WB_rd_idx_o, WB_rd_wdata_o} !== e) begin tests_failed++; $display("FAIL alu_retire[%0d]: got %h exp %h", i-1, {WB_pc_o, WB_rd_wen_o, WB_rd_idx_o, WB_rd_wdata_o}, e); end
      end
      if (i < n) begin
        pc  = 32'h100 + 4 * i;
        rd  = (i < 2) ? 5'd5 : (i == 2) ? 5'd0 : 5'($urandom_range(0, 31));
        wen = (i < 3) ? 1'b1 : 1'($urandom_range(0, 1));
        fwd = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : $urandom;
        drive_op(pc, 5'b00000, $urandom, $urandom, fwd, rd, wen);
        exp_q.push_back({pc, wen && (rd != 0), rd, fwd});
      end else begin
        MEM_valid_i = 0;
      end
      @(negedge clk);
    end
    tests_run++; if (WB_valid_o !== 1'b0) begin tests_failed++; $display("FAIL alu_drain: got %b exp 0", WB_valid_o); end
  endtask

  task automatic test_load_store_directed();
    logic req, we, stb, v, wen, ldm, stm, berr;
    logic [31:0] a, wd, rwd;
    logic [3:0]  ws;
    int lat;
    run_mem(5'b00001, 32'h1003, 0, 0, 32'h80FF_0000, 5'd7, 1, 0, 0, 0, req, a, wd, ws, we, stb, lat, v, wen, ldm, stm, berr, rwd);
    tests_run++; if ({req, we, a, ws} !== {1'b1, 1'b0, 32'h1000, 4'b0000}) begin tests_failed++; $display("FAIL lb_req: got %b %b %h %b exp 1 0 00001000 0000", req, we, a, ws); end
    tests_run++; if ({v, wen, rwd} !== {1'b1, 1'b1, 32'hFFFF_FF80}) begin tests_failed++; $display("FAIL lb_data: got %b %b %h exp 1 1 ffffff80", v, wen, rwd); end
    tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL lb_latency: got %0d exp 3", lat); end
    run_mem(5'b10001, 32'h1003, 0, 0, 32'h80FF_0000, 5'd7, 1, 0, 0, 0, req, a, wd, ws, we, stb, lat, v, wen, ldm, stm, berr, rwd);
    tests_run++; if ({v, wen, rwd} !== {1'b1, 1'b1, 32'h0000_0080}) begin tests_failed++; $display("FAIL lbu_data: got %b %b %h exp 1 1 00000080", v, wen, rwd); end
    run_mem(5'b00110, 32'h2002, 32'h1234, 0, 0, 5'd0, 0, 3, 1, 0, req, a, wd, ws, we, stb, lat, v, wen, ldm, stm, berr, rwd);
    tests_run++; if ({req, we, a, wd, ws} !== {1'b1, 1'b1, 32'h2000, 32'h1234_1234, 4'b1100}) begin tests_failed++; $display("FAIL sh_req: got %b %b %h %h %b exp 1 1 00002000 12341234 1100", req, we, a, wd, ws); end
    tests_run++; if (stb !== 1'b1) begin tests_failed++; $display("FAIL sh_stable: got %b exp 1", stb); end
    tests_run++; if ({v, wen, lat} !== {1'b1, 1'b0, 32'd7}) begin tests_failed++; $display("FAIL sh_retire: got %b %b %0d exp 1 0 7", v, wen, lat); end
    run_mem(5'b01001, 32'h3001, 0, 0, 0, 5'd3, 1, 0, 0, 0, req, a, wd, ws, we, stb, lat, v, wen, ldm, stm, berr, rwd);
    tests_run++; if ({req, v, wen, ldm, stm, lat} !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1}) begin tests_failed++; $display("FAIL lw_misalign: got req%b v%b wen%b ldm%b stm%b lat%0d exp 0 1 0 1 0 1", req, v, wen, ldm, stm, lat); end
    run_mem(5'b01010, 32'h3002, 0, 0, 0, 5'd3, 0, 0, 0, 0, req, a, wd, ws, we, stb, lat, v, wen, ldm, stm, berr, rwd);
    tests_run++; if ({req, v, ldm, stm} !== {1'b0, 1'b1, 1'b0, 1'b1}) begin tests_failed++; $display("FAIL sw_misalign: got req%b v%b ldm%b stm%b exp 0 1 0 1", req, v, ldm, stm); end
    run_mem(5'b01001, 32'h4000, 0, 0, 32'hDEAD_BEEF, 5'd9, 1, 1, 2, 1, req, a, wd, ws, we, stb, lat, v, wen, ldm, stm, berr, rwd);
    tests_run++; if ({v, wen, berr} !== {1'b1, 1'b0, 1'b1}) begin tests_failed++; $display("FAIL lw_buserr: got v%b wen%b err%b exp 1 0 1", v, wen, berr); end
    @(negedge clk);
  endtask

  task automatic test_random_mem(input int n);
    logic req, we, stb, v, wen, ldm, stm, berr, err, rwen, is_ld, uns;
    logic [31:0] a, wd, rwd, addr, rs2, fwd, rdata;
    logic [3:0]  ws;
    logic [4:0]  rd;
    logic [1:0]  sz;
    int lat, g, r;
    bit mis;
    for (int i = 0; i < n; i++) begin
      is_ld = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2)); addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      rs2 = $urandom; fwd = $urandom; rdata = $urandom;
      rd = 5'($urandom_range(0, 31)); rwen = 1'($urandom_range(0, 1));
      g = $urandom_range(0, 3); r = $urandom_range(0, 3); err = ($urandom_range(0, 7) == 0);
      mis = model_mis(addr, sz);
      run_mem({uns, sz, ~is_ld, is_ld}, addr, rs2, fwd, rdata, rd, rwen, g, r, err,
              req, a, wd, ws, we, stb, lat, v, wen, ldm, stm, berr, rwd);
      tests_run++; if (req !== !mis) begin tests_failed++; $display("FAIL rnd_req[%0d]: got %b exp %b", i, req, !mis); end
      tests_run++; if (lat !== (mis ? 1 : 3 + g + r)) begin tests_failed++; $display("FAIL rnd_latency[%0d]: got %0d exp %0d", i, lat, mis ? 1 : 3 + g + r); end
      if (!mis) begin
        tests_run++; if ({a, we, stb} !== {addr & 32'hFFFF_FFFC, ~is_ld, 1'b1}) begin tests_failed++; $display("FAIL rnd_bus[%0d]: got %h %b stable%b exp %h %b 1", i, a, we, stb, addr & 32'hFFFF_FFFC, ~is_ld); end
        tests_run++; if (ws !== (is_ld ? 4'b0000 : model_wstrb(addr, sz))) begin tests_failed++; $display("FAIL rnd_wstrb[%0d]: got %b exp %b", i, ws, is_ld ? 4'b0000 : model_wstrb(addr, sz)); end
        if (!is_ld) begin
          tests_run++; if (wd !== model_wdata(rs2, sz)) begin tests_failed++; $display("FAIL rnd_wdata[%0d]: got %h exp %h", i, wd, model_wdata(rs2, sz)); end
        end
      end
      tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL rnd_valid[%0d]: got %b exp 1", i, v); end
      tests_run++; if (wen !== (rwen && rd != 0 && !mis && !(err && !mis))) begin tests_failed++; $display("FAIL rnd_wen[%0d]: got %b exp %b", i, wen, rwen && rd != 0 && !mis && !err); end
      tests_run++; if ({ldm, stm, berr} !== {is_ld && mis, !is_ld && mis, err && !mis}) begin tests_failed++; $display("FAIL rnd_flags[%0d]: got %b%b%b exp %b%b%b", i, ldm, stm, berr, is_ld && mis, !is_ld && mis, err && !mis); end
      if (!is_ld || (!mis && !err)) begin
        tests_run++; if (rwd !== (is_ld ? model_load(rdata, addr, sz, uns) : fwd)) begin tests_failed++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", i, rwd, is_ld ? model_load(rdata, addr, sz, uns) : fwd); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_flush_and_reset();
    // flush while waiting for the response: no retire after rvalid
    drive_op(32'h500, 5'b01001, 32'h600, 0, 0, 5'd4, 1);
    @(negedge clk); MEM_valid_i = 0; dbus_gnt_i = 1;
    @(negedge clk); dbus_gnt_i = 0; flush_i = 1;
    @(negedge clk); flush_i = 0; dbus_rvalid_i = 1; dbus_rdata_i = 32'h1234_5678;
    @(negedge clk); dbus_rvalid_i = 0;
    tests_run++; if ({WB_valid_o, WB_ready_o} !== 2'b01) begin tests_failed++; $display("FAIL flush_resp: got valid%b ready%b exp 0 1", WB_valid_o, WB_ready_o); end
    drive_op(32'h504, 5'b00000, 0, 0, 32'hCAFE_0001, 5'd6, 1);
    @(negedge clk); MEM_valid_i = 0;
    tests_run++; if ({WB_valid_o, WB_rd_wen_o, WB_rd_wdata_o, WB_pc_o} !== {1'b1, 1'b1, 32'hCAFE_0001, 32'h504}) begin tests_failed++; $display("FAIL after_flush: got %b %b %h %h exp 1 1 cafe0001 00000504", WB_valid_o, WB_rd_wen_o, WB_rd_wdata_o, WB_pc_o); end
    // flush in DONE: no retire and no accept that cycle
    flush_i = 1; drive_op(32'h508, 5'b00000, 0, 0, 32'h77, 5'd8, 1);
    #1;
    tests_run++; if (WB_valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_done: got %b exp 0", WB_valid_o); end
    @(negedge clk); flush_i = 0; MEM_valid_i = 0;
    tests_run++; if (WB_valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_noaccept: got %b exp 0", WB_valid_o); end
    // flush in REQ before grant drops the request; stray rvalid is ignored
    drive_op(32'h50C, 5'b01010, 32'h700, 32'h55, 0, 5'd0, 0);
    @(negedge clk); MEM_valid_i = 0; flush_i = 1;
    @(negedge clk); flush_i = 0; dbus_rvalid_i = 1;
    tests_run++; if ({dbus_req_o, WB_ready_o} !== 2'b01) begin tests_failed++; $display("FAIL flush_req: got req%b ready%b exp 0 1", dbus_req_o, WB_ready_o); end
    @(negedge clk); dbus_rvalid_i = 0;
    tests_run++; if (WB_valid_o !== 1'b0) begin tests_failed++; $display("FAIL stray_rvalid: got %b exp 0", WB_valid_o); end
    // reset in REQ returns to IDLE next cycle
    drive_op(32'h510, 5'b01001, 32'h800, 0, 0, 5'd2, 1);
    @(negedge clk); MEM_valid_i = 0;
    tests_run++; if (dbus_req_o !== 1'b1) begin tests_failed++; $display("FAIL pre_rst_req: got %b exp 1", dbus_req_o); end
    rst = 1;
    @(negedge clk); rst = 0;
    tests_run++; if ({dbus_req_o, WB_ready_o, WB_valid_o} !== 3'b010) begin tests_failed++; $display("FAIL rst_in_req: got req%b ready%b valid%b exp 0 1 0", dbus_req_o, WB_ready_o, WB_valid_o); end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu_back_to_back(24);
    test_load_store_directed();
    test_random_mem(40);
    test_flush_and_reset();
    test_alu_back_to_back(8);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
